// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared constants for the instruction-fetch / data-memory port arbiter:
// controller state encodings, fixed datapath widths and the default
// starvation limit.
// ----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  // Controller state encoding
  localparam int STATE_W = 2;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_BUSY_IF  = 2'd1;
  localparam logic [1:0] ST_BUSY_DM  = 2'd2;
  localparam logic [1:0] ST_DRAIN_IF = 2'd3;

  // Instruction width returned to the fetch stage
  localparam int IF_W = 32;

  // Byte-offset bits inside one 64-bit memory word
  localparam int WORD_OFS_W = 3;

  // Default number of back-to-back data grants tolerated while a fetch waits
  localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between the instruction-fetch stage and the data
// memory stage. Data accesses normally win; a starvation counter forces a
// fetch grant after STARVE_MAX consecutive data grants. Exactly one memory
// transaction is outstanding at a time.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   if_req, if_addr          fetch request and byte address
//   if_valid, if_rdata       one-cycle fetch completion pulse and instruction
//   dm_req, dm_we, dm_addr,
//   dm_wdata                 data load/store request
//   dm_valid, dm_rdata       one-cycle data completion pulse and load data
//   flush                    discard pending / in-flight fetch
//   mem_req, mem_we,
//   mem_addr, mem_wdata      registered request to the shared memory port
//   mem_ready, mem_rdata     memory completion and read data
//   stall_if, stall_mem      pipeline hold requests
// ----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [IF_W-1:0]   if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  // Memory is accessed in whole 64-bit words
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:WORD_OFS_W], {WORD_OFS_W{1'b0}}};
  endfunction

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               hi_sel_q, hi_sel_d;
  logic               if_valid_q, if_valid_d;
  logic [IF_W-1:0]    if_rdata_q, if_rdata_d;
  logic               dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0]  dm_rdata_q, dm_rdata_d;

  logic fetch_ok;
  logic can_grant;
  logic grant_if;
  logic grant_dm;
  logic unused_addr_bits;

  // Sub-word address bits never reach the memory port
  assign unused_addr_bits = ^{if_addr[1:0], dm_addr[WORD_OFS_W-1:0]};

  // A flushed fetch is not eligible in the cycle the flush is seen
  assign fetch_ok = if_req & ~flush;

  // No new grant while a completion pulse is being presented
  assign can_grant = (state_q == ST_IDLE) & ~if_valid_q & ~dm_valid_q;

  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (can_grant) begin
      if (fetch_ok && (!dm_req || (starve_q == CNT_MAX))) begin
        grant_if = 1'b1;
      end else if (dm_req) begin
        grant_dm = 1'b1;
      end
    end
  end

  // Starvation counter: counts data grants that overtook a waiting fetch
  always_comb begin
    starve_d = starve_q;
    if (!if_req || grant_if) begin
      starve_d = '0;
    end else if (grant_dm && (starve_q != CNT_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hi_sel_d    = hi_sel_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_valid_d  = 1'b0;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      ST_IDLE: begin
        // mem_ready arriving here belongs to an abandoned transaction
        if (grant_if) begin
          state_d    = ST_BUSY_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = word_align(if_addr);
          hi_sel_d   = if_addr[WORD_OFS_W-1];
        end else if (grant_dm) begin
          state_d     = ST_BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = word_align(dm_addr);
          mem_wdata_d = dm_wdata;
        end
      end

      ST_BUSY_IF: begin
        if (mem_ready) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          // A flush coinciding with completion still discards the word
          if (!flush) begin
            if_valid_d = 1'b1;
            if_rdata_d = hi_sel_q ? mem_rdata[2*IF_W-1:IF_W] : mem_rdata[IF_W-1:0];
          end
        end else if (flush) begin
          state_d = ST_DRAIN_IF;
        end
      end

      ST_BUSY_DM: begin
        if (mem_ready) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          dm_valid_d = 1'b1;
          dm_rdata_d = mem_rdata;
        end
      end

      ST_DRAIN_IF: begin
        // The memory still owes a response; swallow it silently
        if (mem_ready) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hi_sel_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_valid_q  <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hi_sel_q    <= hi_sel_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      dm_valid_q  <= dm_valid_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign dm_rdata  = dm_rdata_q;

  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model tracks port ownership, starvation and completions and is
// compared against the DUT every cycle.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, flush, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr;
  logic [63:0] dm_wdata, mem_rdata;
  logic        if_valid, dm_valid, mem_req, mem_we, stall_if, stall_mem;
  logic [31:0] if_rdata, mem_addr;
  logic [63:0] dm_rdata, mem_wdata;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_valid  (dm_valid),
    .dm_rdata  (dm_rdata),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Bench knobs
  bit          mem_auto  = 1'b1;
  bit          rand_mode = 1'b0;
  int          lat_fix   = -1;
  bit          fix_rdata = 1'b0;
  logic [63:0] rdata_val = 64'h0;
  int          lat       = 0;
  bit          grant_seen = 1'b0;
  bit          prev_req   = 1'b0;

  // Reference model: who owns the port and what completes when
  bit          m_busy, m_is_f, m_killed, m_cool;
  int          m_starve;
  logic [31:0] m_addr;
  logic        m_we, m_hi;
  logic [63:0] m_wdata;
  bit          e_ifv, e_dmv;
  logic [31:0] e_if_rdata;
  logic [63:0] e_dm_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  // Applies one clock edge to the model using the inputs present at that edge
  task automatic model_edge();
    bit take_f, take_d;
    e_ifv  = 1'b0;
    e_dmv  = 1'b0;
    take_f = 1'b0;
    take_d = 1'b0;
    if (rst) begin
      m_busy = 0; m_cool = 0; m_starve = 0; m_killed = 0;
      return;
    end
    if (m_busy) begin
      if (m_is_f && flush) m_killed = 1;
      if (mem_ready) begin
        m_busy = 0;
        if (!m_is_f) begin
          e_dmv = 1; e_dm_rdata = mem_rdata;
        end else if (!m_killed) begin
          e_ifv = 1; e_if_rdata = m_hi ? mem_rdata[63:32] : mem_rdata[31:0];
        end
      end
    end else if (!m_cool) begin
      if (if_req && !flush && (!dm_req || m_starve == STARVE)) take_f = 1;
      else if (dm_req) take_d = 1;
    end
    if (take_f) begin
      m_busy = 1; m_is_f = 1; m_killed = 0; m_we = 0;
      m_addr = if_addr & ~32'h7; m_hi = if_addr[2];
    end
    if (take_d) begin
      m_busy = 1; m_is_f = 0; m_killed = 0; m_we = dm_we;
      m_addr = dm_addr & ~32'h7; m_wdata = dm_wdata;
    end
    if (!if_req || take_f) m_starve = 0;
    else if (take_d && m_starve < STARVE) m_starve++;
    m_cool = e_ifv | e_dmv;
  endtask

  task automatic check_outputs();
    chk("mem_req", mem_req, m_busy);
    chk("if_valid", if_valid, e_ifv);
    chk("dm_valid", dm_valid, e_dmv);
    if (e_ifv) chk("if_rdata", if_rdata, e_if_rdata);
    if (e_dmv && !m_we) chk("dm_rdata", dm_rdata, e_dm_rdata);
    if (m_busy) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      if (!m_is_f) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("stall_if", stall_if, if_req & ~e_ifv);
    chk("stall_mem", stall_mem, dm_req & ~e_dmv);
  endtask

  task automatic drive_mem();
    if (grant_seen) lat = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 3);
    if (mem_req && !mem_ready) begin
      if (lat == 0) begin
        mem_ready = 1'b1;
        mem_rdata = fix_rdata ? rdata_val : {$urandom, $urandom};
      end else begin
        lat--;
      end
    end else begin
      mem_ready = 1'b0;
      if (rand_mode && !mem_req && $urandom_range(0, 7) == 0) begin
        mem_ready = 1'b1;
        mem_rdata = {$urandom, $urandom};
      end
    end
  endtask

  task automatic drive_reqs();
    if (!if_req || if_valid) begin
      if_req  = ($urandom_range(0, 3) != 0);
      if_addr = $urandom & 32'h0000_FFFC;
    end
    flush = 1'b0;
    if (if_req && !if_valid && $urandom_range(0, 11) == 0) begin
      flush   = 1'b1;
      if_addr = $urandom & 32'h0000_FFFC;
    end
    if (!dm_req || dm_valid) begin
      dm_req   = ($urandom_range(0, 2) != 0);
      dm_we    = $urandom_range(0, 1);
      dm_addr  = $urandom;
      dm_wdata = {$urandom, $urandom};
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_outputs();
    grant_seen = mem_req && !prev_req;
    prev_req   = mem_req;
    if (mem_auto) drive_mem();
    if (rand_mode) drive_reqs();
  endtask

  // which: 0 = new grant, 1 = if_valid, 2 = dm_valid
  task automatic wait_ev(input int which, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step();
      case (which)
        0:       hit = grant_seen;
        1:       hit = if_valid;
        default: hit = dm_valid;
      endcase
    end
    if (!hit) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    logic [5:0] order;
    int         ng;

    rst = 1'b1; if_req = 0; flush = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    step();
    step();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_valid", dm_valid, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    rst = 1'b0;
    step();

    // Fetch of the upper instruction in a word
    lat_fix = 1; fix_rdata = 1; rdata_val = 64'hAAAA_BBBB_1111_2222;
    if_req = 1; if_addr = 32'h104;
    wait_ev(0, "d1_grant");
    chk("d1_mem_addr", mem_addr, 32'h100);
    chk("d1_mem_we", mem_we, 0);
    wait_ev(1, "d1_valid");
    chk("d1_if_rdata", if_rdata, 32'hAAAABBBB);
    if_req = 0;
    step();
    chk("d1_pulse_len", if_valid, 0);

    // Simultaneous fetch and store: data goes first
    lat_fix = 0;
    if_req = 1; if_addr = 32'h200;
    dm_req = 1; dm_we = 1; dm_addr = 32'h2008; dm_wdata = 64'h55;
    wait_ev(0, "d2_grant_d");
    chk("d2_first_we", mem_we, 1);
    chk("d2_first_addr", mem_addr, 32'h2008);
    chk("d2_first_wdata", mem_wdata, 64'h55);
    wait_ev(2, "d2_dm_valid");
    dm_req = 0;
    wait_ev(0, "d2_grant_f");
    chk("d2_second_addr", mem_addr, 32'h200);
    chk("d2_second_we", mem_we, 0);
    wait_ev(1, "d2_if_valid");
    if_req = 0;
    step();

    // Starvation limit forces a fetch in
    if_req = 1; if_addr = 32'h400;
    dm_req = 1; dm_we = 1; dm_addr = 32'h8000; dm_wdata = 64'h77;
    order = '0; ng = 0;
    for (int i = 0; i < 80 && ng < 6; i++) begin
      step();
      if (grant_seen) begin
        order = {order[4:0], (mem_addr == 32'h400)};
        ng++;
      end
    end
    chk("d3_grants", ng, 6);
    chk("d3_order", order, 6'b000010);
    if_req = 0; dm_req = 0;
    for (int i = 0; i < 8; i++) step();

    // Flush of an in-flight fetch
    lat_fix = 3;
    if_req = 1; if_addr = 32'h600;
    wait_ev(0, "d4_grant");
    step();
    flush = 1;
    step();
    flush = 0; if_req = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("d4_no_if_valid", if_valid, 0);
    end
    lat_fix = 0;
    if_req = 1; if_addr = 32'h700;
    wait_ev(0, "d4_regrant");
    chk("d4_regrant_addr", mem_addr, 32'h700);
    wait_ev(1, "d4_if_valid");
    chk("d4_if_rdata", if_rdata, 32'h1111_2222);
    if_req = 0;
    step();

    // Asynchronous reset in the middle of a load
    mem_auto = 0; mem_ready = 0;
    dm_req = 1; dm_we = 0; dm_addr = 32'h3000;
    wait_ev(0, "d5_grant");
    step();
    #2 rst = 1'b1;
    #1;
    chk("d5_async_mem_req", mem_req, 0);
    chk("d5_async_dm_valid", dm_valid, 0);
    dm_req = 0;
    step();
    rst = 1'b0;
    mem_ready = 1; mem_rdata = 64'hDEAD_BEEF_0000_0001;
    step();
    mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("d5_no_dm_valid", dm_valid, 0);
    end
    mem_auto = 1;

    // Randomized traffic with flushes, variable latency and occasional reset
    lat_fix = -1; fix_rdata = 0; rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 0; rand_mode = 0;
    if_req = 0; dm_req = 0; flush = 0;
    for (int i = 0; i < 10; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
